wb_write_queue: RTL and testbench

- Writer-side front end for the 32x32 register file write port (RDaddr/RDdata/RegWrite).
- Accepts writeback requests from two producers: the single-cycle ALU path and the multi-cycle mul/div unit. Both can complete in the same cycle.
- Buffers requests in an in-order FIFO and drains at most one write per cycle into the register file.
- Exposes a pending-write lookup so decode can forward values not yet committed.

---
 rtl/wb_write_queue.sv | 114 +++++++++++
 tb/tb_wb_write_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue: merges ALU and mul/div results into an in-order FIFO,
// drains one register-file write per cycle and exposes pending-write forwarding.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alu_valid_i,
    input  logic [AW-1:0]                alu_addr_i,
    input  logic [DW-1:0]                alu_data_i,
    output logic                         alu_ready_o,
    input  logic                         md_valid_i,
    input  logic [AW-1:0]                md_addr_i,
    input  logic [DW-1:0]                md_data_i,
    output logic                         md_ready_o,
    input  logic                         stall_i,
    output logic                         RegWrite_o,
    output logic [AW-1:0]                RDaddr_o,
    output logic [DW-1:0]                RDdata_o,
    input  logic [AW-1:0]                fwd_addr_i,
    output logic                         fwd_hit_o,
    output logic [DW-1:0]                fwd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic [CW-1:0]    free;
    logic             alu_acc;
    logic             md_acc;
    logic             alu_enq;
    logic             md_enq;
    logic             deq;
    logic [PW-1:0]    md_ptr;
    logic [PW-1:0]    fidx;

    // Handshake and enqueue decisions; room is judged from registered count only
    always_comb begin
        free        = CW'(DEPTH) - count_q;
        alu_ready_o = (free >= CW'(1)) & ~rst_i;
        alu_acc     = alu_valid_i & alu_ready_o;
        md_ready_o  = (free >= (CW'(1) + CW'(alu_acc))) & ~rst_i;
        md_acc      = md_valid_i & md_ready_o;
        // writes to r0 finish the handshake but are never stored
        alu_enq     = alu_acc & (alu_addr_i != '0);
        md_enq      = md_acc & (md_addr_i != '0);
        md_ptr      = wr_ptr_q + PW'(alu_enq);
    end

    // Drain port: head entry is presented whenever the queue is non-empty
    always_comb begin
        empty_o    = (count_q == '0);
        full_o     = (count_q == CW'(DEPTH));
        count_o    = count_q;
        RegWrite_o = ~empty_o & ~stall_i;
        deq        = RegWrite_o;
        RDaddr_o   = empty_o ? '0 : addr_q[rd_ptr_q];
        RDdata_o   = empty_o ? '0 : data_q[rd_ptr_q];
    end

    // Forwarding lookup: walk oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fidx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fidx = rd_ptr_q + PW'(i);
            if (vld_q[fidx] && (fwd_addr_i != '0) && (addr_q[fidx] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[fidx];
            end
        end
    end

    // Pointer, count and valid-bit update; ALU entry is older than mul/div entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (deq) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PW'(1);
            end
            if (alu_enq) begin
                addr_q[wr_ptr_q] <= alu_addr_i;
                data_q[wr_ptr_q] <= alu_data_i;
                vld_q[wr_ptr_q]  <= 1'b1;
            end
            if (md_enq) begin
                addr_q[md_ptr] <= md_addr_i;
                data_q[md_ptr] <= md_data_i;
                vld_q[md_ptr]  <= 1'b1;
            end
            wr_ptr_q <= wr_ptr_q + PW'(alu_enq) + PW'(md_enq);
            count_q  <= count_q + CW'(alu_enq) + CW'(md_enq) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed cycle table plus randomized run against a queue model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          av, mv, st;
    logic [AW-1:0] aa, ma, fa;
    logic [DW-1:0] ad, md;
    logic          alu_ready, md_ready, reg_write, fwd_hit, full, empty;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, fwd_data;
    logic [CW-1:0] count;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(av), .alu_addr_i(aa), .alu_data_i(ad), .alu_ready_o(alu_ready),
        .md_valid_i(mv), .md_addr_i(ma), .md_data_i(md), .md_ready_o(md_ready),
        .stall_i(st),
        .RegWrite_o(reg_write), .RDaddr_o(rd_addr), .RDdata_o(rd_data),
        .fwd_addr_i(fa), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, av, mv, st;
        int   aa, ad, ma, md, fa;
        logic ar, mr, we, fh;
        int   ra, rd, fd, cnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic a_v, input int a_a, input int a_d,
                       input logic m_v, input int m_a, input int m_d, input logic s, input int f_a,
                       input logic e_ar, input logic e_mr, input logic e_we, input int e_ra,
                       input int e_rd, input logic e_fh, input int e_fd, input int e_cnt);
        vec_t v;
        v.rst = r; v.av = a_v; v.aa = a_a; v.ad = a_d; v.mv = m_v; v.ma = m_a; v.md = m_d;
        v.st = s; v.fa = f_a; v.ar = e_ar; v.mr = e_mr; v.we = e_we; v.ra = e_ra; v.rd = e_rd;
        v.fh = e_fh; v.fd = e_fd; v.cnt = e_cnt;
        tbl.push_back(v);
    endtask

    // Reference: queue semantics applied at the clock edge from the current inputs
    task automatic model_update();
        int  free;
        bit  aacc, macc;
        if (rst) begin
            mq.delete();
            return;
        end
        free = int'(DEPTH) - mq.size();
        aacc = av && (free >= 1);
        macc = mv && (free >= 1 + int'(aacc));
        if (mq.size() > 0 && !st) void'(mq.pop_front());
        if (aacc && aa != 0) mq.push_back('{aa, ad});
        if (macc && ma != 0) mq.push_back('{ma, md});
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_common(input string tag, input logic e_ar, input logic e_mr,
                                input logic e_we, input logic [AW-1:0] e_ra,
                                input logic [DW-1:0] e_rd, input logic e_fh,
                                input logic [DW-1:0] e_fd, input int e_cnt);
        chk({tag, ".alu_ready"}, DW'(alu_ready), DW'(e_ar));
        chk({tag, ".md_ready"},  DW'(md_ready),  DW'(e_mr));
        chk({tag, ".RegWrite"},  DW'(reg_write), DW'(e_we));
        chk({tag, ".RDaddr"},    DW'(rd_addr),   DW'(e_ra));
        chk({tag, ".RDdata"},    rd_data,        e_rd);
        chk({tag, ".fwd_hit"},   DW'(fwd_hit),   DW'(e_fh));
        chk({tag, ".fwd_data"},  fwd_data,       e_fd);
        chk({tag, ".count"},     DW'(count),     DW'(e_cnt));
        chk({tag, ".full"},      DW'(full),      DW'(e_cnt == int'(DEPTH)));
        chk({tag, ".empty"},     DW'(empty),     DW'(e_cnt == 0));
    endtask

    initial begin
        // rst av aa ad  mv ma md  st fa | ar mr we ra rd fh fd cnt
        // single ALU write to r8
        add(0,1,8,'h1234, 0,0,0, 0,8,  1,1,0,0,0,       0,0,0);
        add(0,0,0,0,      0,0,0, 0,8,  1,1,1,8,'h1234,  1,'h1234,1);
        add(0,0,0,0,      0,0,0, 0,8,  1,1,0,0,0,       0,0,0);
        // dual same-cycle enqueue, ALU older
        add(0,1,3,'hA,    1,4,'hB, 0,4, 1,1,0,0,0,      0,0,0);
        add(0,0,0,0,      0,0,0, 0,4,  1,1,1,3,'hA,     1,'hB,2);
        add(0,0,0,0,      0,0,0, 0,4,  1,1,1,4,'hB,     1,'hB,1);
        add(0,0,0,0,      0,0,0, 0,4,  1,1,0,0,0,       0,0,0);
        // fill under stall; at count 3 MD loses to ALU
        add(0,1,1,'h101,  0,0,0, 1,0,  1,1,0,0,0,       0,0,0);
        add(0,1,2,'h102,  0,0,0, 1,0,  1,1,0,1,'h101,   0,0,1);
        add(0,1,3,'h103,  0,0,0, 1,0,  1,1,0,1,'h101,   0,0,2);
        add(0,1,4,'h104,  1,9,'h99, 1,0, 1,0,0,1,'h101, 0,0,3);
        add(0,0,0,0,      1,9,'h99, 1,4, 0,0,0,1,'h101, 1,'h104,4);
        // release stall; MD accepted once a slot frees
        add(0,0,0,0,      1,9,'h99, 0,0, 0,0,1,1,'h101, 0,0,4);
        add(0,0,0,0,      1,9,'h99, 0,0, 1,1,1,2,'h102, 0,0,3);
        add(0,0,0,0,      0,0,0, 0,9,  1,1,1,3,'h103,   1,'h99,3);
        add(0,0,0,0,      0,0,0, 0,0,  1,1,1,4,'h104,   0,0,2);
        add(0,0,0,0,      0,0,0, 0,0,  1,1,1,9,'h99,    0,0,1);
        add(0,0,0,0,      0,0,0, 0,0,  1,1,0,0,0,       0,0,0);
        // forwarding: youngest of two r5 writes, r0 never hits, r0 write dropped
        add(0,1,5,'h11,   0,0,0, 1,5,  1,1,0,0,0,       0,0,0);
        add(0,1,5,'h22,   0,0,0, 1,5,  1,1,0,5,'h11,    1,'h11,1);
        add(0,0,0,0,      0,0,0, 1,5,  1,1,0,5,'h11,    1,'h22,2);
        add(0,0,0,0,      0,0,0, 1,0,  1,1,0,5,'h11,    0,0,2);
        add(0,0,0,0,      1,0,'h77, 1,5, 1,1,0,5,'h11,  1,'h22,2);
        add(0,0,0,0,      0,0,0, 1,5,  1,1,0,5,'h11,    1,'h22,2);
        // mid-operation reset with three pending entries
        add(0,1,6,'h33,   0,0,0, 1,6,  1,1,0,5,'h11,    0,0,2);
        add(1,1,7,'h44,   0,0,0, 1,5,  0,0,0,5,'h11,    1,'h22,3);
        add(0,0,0,0,      0,0,0, 0,5,  1,1,0,0,0,       0,0,0);
        add(0,1,12,'h55,  0,0,0, 0,7,  1,1,0,0,0,       0,0,0);
        add(0,0,0,0,      0,0,0, 0,12, 1,1,1,12,'h55,   1,'h55,1);
        add(0,0,0,0,      0,0,0, 0,6,  1,1,0,0,0,       0,0,0);

        rst = 1'b1; av = 0; mv = 0; st = 0; aa = '0; ma = '0; fa = '0; ad = '0; md = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; av = tbl[i].av; mv = tbl[i].mv; st = tbl[i].st;
            aa = AW'(tbl[i].aa); ad = DW'(tbl[i].ad);
            ma = AW'(tbl[i].ma); md = DW'(tbl[i].md);
            fa = AW'(tbl[i].fa);
            #1;
            check_common($sformatf("vec%0d", i), tbl[i].ar, tbl[i].mr, tbl[i].we,
                         AW'(tbl[i].ra), DW'(tbl[i].rd), tbl[i].fh, DW'(tbl[i].fd), tbl[i].cnt);
            cycle();
        end

        for (int n = 0; n < 2000; n++) begin
            int   cnt, free;
            logic e_ar, e_mr, e_fh;
            logic [DW-1:0] e_fd;
            rst = ($urandom_range(0, 99) == 0);
            av  = ($urandom_range(0, 2) != 0);
            mv  = ($urandom_range(0, 2) != 0);
            st  = ($urandom_range(0, 3) == 0);
            aa  = AW'($urandom_range(0, 7));
            ma  = AW'($urandom_range(0, 7));
            fa  = AW'($urandom_range(0, 7));
            ad  = $urandom;
            md  = $urandom;
            #1;
            cnt  = mq.size();
            free = int'(DEPTH) - cnt;
            e_ar = (free >= 1) && !rst;
            e_mr = (free >= 1 + int'(av && e_ar)) && !rst;
            e_fh = 1'b0;
            e_fd = '0;
            if (fa != 0)
                foreach (mq[k])
                    if (mq[k].a == fa) begin
                        e_fh = 1'b1;
                        e_fd = mq[k].d;
                    end
            check_common($sformatf("rnd%0d", n), e_ar, e_mr, (cnt > 0) && !st,
                         (cnt > 0) ? mq[0].a : AW'(0), (cnt > 0) ? mq[0].d : DW'(0),
                         e_fh, e_fd, cnt);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
